// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - oversampling UART receiver with majority vote, optional parity and RX FIFO
module uart_rx_param #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rxd,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun
);

  localparam int DIV   = (CLK_HZ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  VOTE_A    = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  VOTE_B    = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0]  VOTE_C    = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_WAIT_HI
  } state_t;

  state_t r_state, w_next;

  logic                 r_sync1, r_rxs, r_rxs_prev;
  logic [DIV_W-1:0]     r_div_cnt;
  logic [OS_W-1:0]      r_os_cnt;
  logic                 r_vote_a, r_vote_b;
  logic [DATA_BITS-1:0] r_shift;
  logic [3:0]           r_bit_cnt;
  logic                 r_par_bad;
  logic                 r_push, r_frame_err, r_parity_err, r_overrun;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wptr, r_rptr;
  logic [CNT_W-1:0]     r_count;

  logic w_start_edge, w_tick, w_sample, w_maj, w_par_exp;
  logic w_push, w_fe, w_pe;
  logic w_empty, w_full, w_rd, w_wr, w_overrun;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1    <= 1'b1;
      r_rxs      <= 1'b1;
      r_rxs_prev <= 1'b1;
    end else begin
      r_sync1    <= rxd;
      r_rxs      <= r_sync1;
      r_rxs_prev <= r_rxs;
    end
  end

  assign w_start_edge = (r_state == S_IDLE) && r_rxs_prev && !r_rxs;
  assign w_tick       = (r_div_cnt == DIV_LAST);
  assign w_sample     = w_tick && (r_os_cnt == VOTE_C);
  assign w_maj        = (r_vote_a & r_vote_b) | (r_vote_a & r_rxs) | (r_vote_b & r_rxs);
  assign w_par_exp    = (PARITY == 1) ? ~^r_shift : ^r_shift;

  // Realigning the tick phase to the start edge puts vote ticks around each bit centre
  always_ff @(posedge clk) begin
    if (reset || w_start_edge) begin
      r_div_cnt <= '0;
      r_os_cnt  <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
      r_os_cnt  <= (r_os_cnt == OS_LAST) ? '0 : r_os_cnt + 1'b1;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vote_a <= 1'b1;
      r_vote_b <= 1'b1;
    end else if (w_tick) begin
      if (r_os_cnt == VOTE_A) r_vote_a <= r_rxs;
      if (r_os_cnt == VOTE_B) r_vote_b <= r_rxs;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_push = 1'b0;
    w_fe   = 1'b0;
    w_pe   = 1'b0;
    case (r_state)
      S_IDLE:    if (w_start_edge) w_next = S_START;
      S_START:   if (w_sample) w_next = w_maj ? S_IDLE : S_DATA;
      S_DATA:    if (w_sample && r_bit_cnt == DATA_LAST)
                   w_next = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:     if (w_sample) w_next = S_STOP;
      S_STOP: begin
        if (w_sample) begin
          if (!w_maj) begin
            w_fe   = 1'b1;
            w_next = S_WAIT_HI;
          end else if (r_bit_cnt == STOP_LAST) begin
            w_pe   = r_par_bad;
            w_push = !r_par_bad;
            w_next = S_IDLE;
          end
        end
      end
      S_WAIT_HI: if (r_rxs) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_par_bad    <= 1'b0;
      r_push       <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_push       <= w_push;
      r_frame_err  <= w_fe;
      r_parity_err <= w_pe;
      if (w_start_edge) begin
        r_bit_cnt <= '0;
        r_par_bad <= 1'b0;
      end else if (w_sample) begin
        case (r_state)
          S_DATA: begin
            r_shift   <= {w_maj, r_shift[DATA_BITS-1:1]};
            r_bit_cnt <= (r_bit_cnt == DATA_LAST) ? '0 : r_bit_cnt + 1'b1;
          end
          S_PAR:   r_par_bad <= (w_maj != w_par_exp);
          S_STOP:  r_bit_cnt <= r_bit_cnt + 1'b1;
          default: ;
        endcase
      end
    end
  end

  // r_shift stays stable in IDLE until the next frame's data bits, so it is the write data
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_FULL);
  assign w_rd      = rd_en && !w_empty;
  assign w_wr      = r_push && (!w_full || w_rd);
  assign w_overrun = r_push && w_full && !w_rd;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= r_shift;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_overrun;
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      if (w_wr && !w_rd)      r_count <= r_count + 1'b1;
      else if (!w_wr && w_rd) r_count <= r_count - 1'b1;
    end
  end

  assign rd_valid   = !w_empty;
  assign rd_data    = w_empty ? '0 : r_mem[r_rptr];
  assign fifo_count = r_count;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed bench: 8N1 receiver and an even-parity receiver on a scaled clock
module tb_uart_rx_param;

  localparam int BIT = 160;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, rxd0, rxd1, rd_en0, rd_en1;
  logic [7:0] rd_data0, rd_data1;
  logic       rd_valid0, rd_valid1;
  logic [2:0] cnt0, cnt1;
  logic       fe0, pe0, ov0, fe1, pe1, ov1;

  int n_fe0 = 0, n_pe0 = 0, n_ov0 = 0, n_fe1 = 0, n_pe1 = 0, n_ov1 = 0;
  int total = 0, bad = 0;

  uart_rx_param #(.CLK_HZ(1_600_000), .BAUD(10_000)) dut0 (
    .clk(clk), .reset(reset), .rxd(rxd0), .rd_en(rd_en0),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .fifo_count(cnt0),
    .frame_err(fe0), .parity_err(pe0), .overrun(ov0)
  );

  uart_rx_param #(.CLK_HZ(1_600_000), .BAUD(10_000), .PARITY(2)) dut1 (
    .clk(clk), .reset(reset), .rxd(rxd1), .rd_en(rd_en1),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .fifo_count(cnt1),
    .frame_err(fe1), .parity_err(pe1), .overrun(ov1)
  );

  always @(posedge clk) begin
    if (fe0) n_fe0 <= n_fe0 + 1;
    if (pe0) n_pe0 <= n_pe0 + 1;
    if (ov0) n_ov0 <= n_ov0 + 1;
    if (fe1) n_fe1 <= n_fe1 + 1;
    if (pe1) n_pe1 <= n_pe1 + 1;
    if (ov1) n_ov1 <= n_ov1 + 1;
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_fe;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 0) rxd0 = v;
    else            rxd1 = v;
  endtask

  // Leaves the line at the stop-bit level so a held-low break can follow
  task automatic send(input int which, input logic [7:0] d, input logic use_par,
                      input logic par, input logic stop);
    set_line(which, 1'b0);
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      set_line(which, d[i]);
      idle(BIT);
    end
    if (use_par) begin
      set_line(which, par);
      idle(BIT);
    end
    set_line(which, stop);
    idle(BIT);
  endtask

  task automatic pop0();
    @(negedge clk) rd_en0 = 1'b1;
    @(negedge clk) rd_en0 = 1'b0;
  endtask

  initial begin
    int fe_b, pe_b, ov_b;
    logic [7:0] t2 [5];
    logic [7:0] c3;

    vecs[0] = '{8'h01, 1'b1, 1'b0};
    vecs[1] = '{8'h55, 1'b0, 1'b1};
    vecs[2] = '{8'hA5, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'h80, 1'b0, 1'b1};
    vecs[6] = '{8'h7E, 1'b1, 1'b0};
    t2[0] = 8'hA5; t2[1] = 8'h3C; t2[2] = 8'h7E; t2[3] = 8'h81; t2[4] = 8'hFF;
    c3 = 8'hC3;

    reset = 1'b1; rxd0 = 1'b1; rxd1 = 1'b1; rd_en0 = 1'b0; rd_en1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rd_valid", rd_valid0, 0);
    check("reset_count", cnt0, 0);
    check("reset_rd_data", rd_data0, 0);
    check("reset_pulses", {fe0, pe0, ov0, fe1, pe1, ov1}, 0);
    reset = 1'b0;
    idle(BIT);

    for (int i = 0; i < 7; i++) begin
      fe_b = n_fe0;
      send(0, vecs[i].data, 1'b0, 1'b0, vecs[i].stop);
      @(negedge clk);
      check($sformatf("vec%0d_frame_err", i), n_fe0 - fe_b, vecs[i].exp_fe);
      check($sformatf("vec%0d_count", i), cnt0, vecs[i].exp_fe ? 0 : 1);
      if (!vecs[i].exp_fe) begin
        check($sformatf("vec%0d_valid", i), rd_valid0, 1);
        check($sformatf("vec%0d_data", i), rd_data0, vecs[i].data);
        pop0();
        check($sformatf("vec%0d_valid_after_pop", i), rd_valid0, 0);
      end
      rxd0 = 1'b1;
      idle(BIT);
    end

    ov_b = n_ov0;
    for (int i = 0; i < 4; i++) send(0, t2[i], 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("t2_no_overrun_yet", n_ov0 - ov_b, 0);
    check("t2_count_full", cnt0, 4);
    send(0, t2[4], 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("t2_overrun", n_ov0 - ov_b, 1);
    check("t2_count_still_full", cnt0, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_read%0d", i), rd_data0, t2[i]);
      pop0();
    end
    check("t2_count_empty", cnt0, 0);
    check("t2_valid_empty", rd_valid0, 0);
    idle(BIT);

    fe_b = n_fe0; pe_b = n_pe0;
    @(negedge clk) rxd0 = 1'b0;
    idle(4);
    rxd0 = 1'b1;
    idle(2 * BIT);
    @(negedge clk);
    check("t3_no_write", cnt0, 0);
    check("t3_no_error", (n_fe0 - fe_b) + (n_pe0 - pe_b), 0);
    send(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("t3_next_frame_data", rd_data0, 8'h5A);
    check("t3_next_frame_count", cnt0, 1);
    pop0();
    idle(BIT);

    fe_b = n_fe0;
    send(0, 8'h55, 1'b0, 1'b0, 1'b0);
    idle(3 * BIT);
    rxd0 = 1'b1;
    idle(BIT);
    send(0, 8'h55, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("t4_frame_err_once", n_fe0 - fe_b, 1);
    check("t4_count", cnt0, 1);
    check("t4_data", rd_data0, 8'h55);
    pop0();
    check("t4_single_entry", rd_valid0, 0);
    idle(BIT);

    pe_b = n_pe1; fe_b = n_fe1;
    send(1, 8'h03, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    check("t5_parity_err", n_pe1 - pe_b, 1);
    check("t5_no_write", cnt1, 0);
    send(1, 8'h03, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("t5_no_second_parity_err", n_pe1 - pe_b, 1);
    check("t5_no_frame_err", n_fe1 - fe_b, 0);
    check("t5_count", cnt1, 1);
    check("t5_data", rd_data1, 8'h03);
    idle(BIT);

    send(0, 8'h11, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("t6_prefill", cnt0, 1);
    idle(BIT);
    fe_b = n_fe0; pe_b = n_pe0;
    rxd0 = 1'b0;
    idle(BIT);
    for (int i = 0; i < 4; i++) begin
      rxd0 = c3[i];
      idle(BIT);
    end
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    rxd0 = 1'b1;
    check("t6_flushed_count", cnt0, 0);
    check("t6_flushed_valid", rd_valid0, 0);
    idle(2 * BIT);
    send(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("t6_count", cnt0, 1);
    check("t6_data", rd_data0, 8'h3C);
    check("t6_no_error", (n_fe0 - fe_b) + (n_pe0 - pe_b), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
